r_egress_arb: RTL

R_EGRESS_ARB -- requirements
Module: r_egress_arb

---
 rtl/r_egress_pkg.sv | 30 +++
 rtl/r_rr_pick.sv | 39 +++
 rtl/r_egress_arb.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/r_egress_pkg.sv
// ---------------------------------------------------------------------------
// r_egress_pkg
// Shared types and constants for the egress arbiter.
//   state_t             : arbiter FSM states (IDLE, ARB, XFER, FLUSH)
//   NUM_PORTS           : number of output FIFOs served (4)
//   PTR_W               : width of a port index / round-robin pointer (2)
//   DEF_TIMEOUT_CYCLES  : default stall timeout in XFER cycles (30)
//   CNT_W               : stall counter width, covers timeouts up to 255
//   next_port()         : port index + 1, wrapping 3 -> 0
// ---------------------------------------------------------------------------
package r_egress_pkg;

    localparam int NUM_PORTS          = 4;
    localparam int PTR_W              = 2;
    localparam int DEF_TIMEOUT_CYCLES = 30;
    localparam int CNT_W              = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_XFER  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    // The index width equals log2(NUM_PORTS), so plain overflow gives mod-4.
    function automatic logic [PTR_W-1:0] next_port(input logic [PTR_W-1:0] p);
        return p + PTR_W'(1);
    endfunction

endpackage

// File: rtl/r_rr_pick.sv
// ---------------------------------------------------------------------------
// r_rr_pick
// Combinational rotating-priority picker: returns the first requesting port
// found scanning ptr, ptr+1, ... (mod NUM_PORTS).
//   req     [3:0] : per-port request (FIFO non-empty)
//   ptr     [1:0] : port with highest priority this cycle
//   gnt_id  [1:0] : selected port (0 when nothing requests)
//   gnt_vld       : at least one port requests
// ---------------------------------------------------------------------------
module r_rr_pick
    import r_egress_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PTR_W-1:0]     ptr,
    output logic [PTR_W-1:0]     gnt_id,
    output logic                 gnt_vld
);

    logic [PTR_W-1:0] w_idx;

    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // any conditional assignment; a path that leaves one unassigned
        // infers a latch.
        gnt_id  = '0;
        gnt_vld = 1'b0;
        w_idx   = '0;
        // Walk from the farthest offset back to ptr so the nearest requester
        // is the last one written and therefore wins.
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            w_idx = ptr + PTR_W'(k);
            if (req[w_idx]) begin
                gnt_id  = w_idx;
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/r_egress_arb.sv
// ---------------------------------------------------------------------------
// r_egress_arb
// Round-robin arbiter draining four output FIFOs onto one shared egress
// channel, one whole packet per grant.
//   clk                : clock, all state on posedge
//   resetn             : synchronous active-low reset
//   fifo_empty   [3:0] : FIFO i holds no data
//   fifo_last    [3:0] : FIFO i head byte is the packet's last byte
//   egress_ready       : egress channel accepts a byte this cycle
//   read_enb     [3:0] : read strobe to the granted FIFO (at most one bit)
//   egress_valid       : a byte moves this cycle (|read_enb)
//   grant_id     [1:0] : granted FIFO, steers the egress mux
//   busy               : arbiter in ARB, XFER or FLUSH
//   soft_reset   [3:0] : one-cycle flush pulse to a FIFO that stalled out
// Build option: define R_EGRESS_TIMEOUT_EN to include the stall counter and
// the FLUSH path; without it XFER waits indefinitely for the last byte and
// soft_reset stays 0.
// ---------------------------------------------------------------------------
module r_egress_arb
    import r_egress_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] fifo_last,
    input  logic                 egress_ready,
    output logic [NUM_PORTS-1:0] read_enb,
    output logic                 egress_valid,
    output logic [PTR_W-1:0]     grant_id,
    output logic                 busy,
    output logic [NUM_PORTS-1:0] soft_reset
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("r_egress_arb: TIMEOUT_CYCLES must be in 2..255");
    end

    state_t               r_state;
    logic [PTR_W-1:0]     r_rr_ptr;
    logic [PTR_W-1:0]     r_grant_id;
    logic                 r_busy;
    logic [NUM_PORTS-1:0] r_soft_reset;

    logic [NUM_PORTS-1:0] w_req;
    logic [PTR_W-1:0]     w_pick_id;
    logic                 w_pick_vld;
    logic                 w_read;
    logic                 w_last_read;
    logic                 w_timeout;

    assign w_req = ~fifo_empty;

    r_rr_pick u_rr_pick (
        .req     (w_req),
        .ptr     (r_rr_ptr),
        .gnt_id  (w_pick_id),
        .gnt_vld (w_pick_vld)
    );

    // Reads are combinational so a byte moves in the same cycle ready is seen.
    assign w_read      = (r_state == ST_XFER) && egress_ready && !fifo_empty[r_grant_id];
    assign w_last_read = w_read && fifo_last[r_grant_id];

    always_comb begin
        read_enb             = '0;
        read_enb[r_grant_id] = w_read;
    end

    assign egress_valid = w_read;
    assign grant_id     = r_grant_id;
    assign busy         = r_busy;
    assign soft_reset   = r_soft_reset;

`ifdef R_EGRESS_TIMEOUT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    // Counter sits at 0 outside XFER, so entering XFER starts from zero.
    assign w_timeout = (r_state == ST_XFER) && !w_read &&
                       (r_stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_stall_cnt <= '0;
        end else if (r_state != ST_XFER || w_read) begin
            r_stall_cnt <= '0;
        end else begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_rr_ptr     <= '0;
            r_grant_id   <= '0;
            r_busy       <= 1'b0;
            r_soft_reset <= '0;
        end else begin
            r_soft_reset <= '0;
            unique case (r_state)
                ST_IDLE: begin
                    if (|w_req) begin
                        r_state <= ST_ARB;
                        r_busy  <= 1'b1;
                    end
                end
                ST_ARB: begin
                    if (w_pick_vld) begin
                        r_state    <= ST_XFER;
                        r_grant_id <= w_pick_id;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_XFER: begin
                    // A last-byte read takes precedence over the timeout.
                    if (w_last_read) begin
                        r_state    <= ST_IDLE;
                        r_busy     <= 1'b0;
                        r_grant_id <= '0;
                        r_rr_ptr   <= next_port(r_grant_id);
                    end else if (w_timeout) begin
                        r_state      <= ST_FLUSH;
                        r_soft_reset <= NUM_PORTS'(1) << r_grant_id;
                    end
                end
                ST_FLUSH: begin
                    r_state    <= ST_IDLE;
                    r_busy     <= 1'b0;
                    r_grant_id <= '0;
                    r_rr_ptr   <= next_port(r_grant_id);
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
